// File: rtl/fifo_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rr_arbiter
//
// Purpose:
//   Lets N_REQ command producers share the write side of one queue. Each
//   cycle at most one requester is granted, chosen round-robin starting at
//   rr_ptr. Every accepted word is stored with the index of the requester
//   that sent it. The queue head is presented on a first-word-fall-through
//   valid/ready master port. A flush sequencer empties the queue on demand.
//
// Optional feature (compile-time macro FIFO_RR_ARB_STRICT0_EN):
//   When defined, requester 0 has strict priority and does not move rr_ptr.
//   Requesters 1..N_REQ-1 round-robin among themselves.
//   When undefined, plain round-robin runs over all N_REQ requesters.
//
// Ports:
//   aclk        in   clock
//   aresetn     in   synchronous active-low reset
//   req_valid   in   [N_REQ]            per-requester word valid
//   req_ready   out  [N_REQ]            per-requester accept (one-hot or zero)
//   req_data    in   [N_REQ*DATA_BITS]  requester i at [i*DATA_BITS +: DATA_BITS]
//   m_valid     out  queue head valid (RUN and not empty)
//   m_ready     in   downstream accept
//   m_data      out  [DATA_BITS]        head payload
//   m_src       out  [SRC_BITS]         head source index
//   flush       in   flush request, sampled in RUN
//   flush_done  out  high for the single cycle a flush completes
//   n_entries   out  [$clog2(FIFO_SIZE+1)] current occupancy
// ---------------------------------------------------------------------------
module fifo_rr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_BITS  = 64,
    parameter int FIFO_SIZE  = 8,
    localparam int SRC_BITS  = $clog2(N_REQ),
    localparam int CNT_BITS  = $clog2(FIFO_SIZE + 1)
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*DATA_BITS-1:0]   req_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_BITS-1:0]         m_data,
    output logic [SRC_BITS-1:0]          m_src,
    input  logic                         flush,
    output logic                         flush_done,
    output logic [CNT_BITS-1:0]          n_entries
);

    localparam int PTR_BITS = $clog2(FIFO_SIZE);

    localparam logic [PTR_BITS-1:0] PTR_LAST  = PTR_BITS'(FIFO_SIZE - 1);
    localparam logic [CNT_BITS-1:0] CNT_FULL  = CNT_BITS'(FIFO_SIZE);
    localparam logic [SRC_BITS-1:0] SRC_LAST  = SRC_BITS'(N_REQ - 1);
    localparam logic [SRC_BITS:0]   N_REQ_EXT = (SRC_BITS + 1)'(N_REQ);
`ifdef FIFO_RR_ARB_STRICT0_EN
    // Size of the ring formed by requesters 1..N_REQ-1.
    localparam logic [SRC_BITS:0]   N_RR_EXT  = (SRC_BITS + 1)'(N_REQ - 1);
`endif

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SRC_BITS-1:0]    rr_ptr_q;
    logic [SRC_BITS-1:0]    rr_ptr_d;
    logic [PTR_BITS-1:0]    wr_ptr_q;
    logic [PTR_BITS-1:0]    wr_ptr_d;
    logic [PTR_BITS-1:0]    rd_ptr_q;
    logic [PTR_BITS-1:0]    rd_ptr_d;
    logic [CNT_BITS-1:0]    count_q;
    logic [CNT_BITS-1:0]    count_d;

    // Queue storage: payload and source tag, not reset.
    logic [DATA_BITS-1:0]   mem_data_q [FIFO_SIZE];
    logic [SRC_BITS-1:0]    mem_src_q  [FIFO_SIZE];

    logic [DATA_BITS-1:0]   req_word_s [N_REQ];
    logic                   grant_found_s;
    logic [SRC_BITS-1:0]    grant_idx_s;
    logic [SRC_BITS:0]      cand_ext_s;
    logic [SRC_BITS-1:0]    cand_idx_s;
    logic                   hit_s;
`ifdef FIFO_RR_ARB_STRICT0_EN
    logic [SRC_BITS-1:0]    rr_start_s;
`endif
    logic                   can_grant_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   drain_s;
    logic                   rd_adv_s;

    // Split the flat request bus into per-requester words.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_word_s[i] = req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    // Grants are only possible in RUN, out of reset, with a free slot.
    // A pop in the same cycle does not free a slot (no pass-through).
    assign can_grant_s = aresetn && (state_q == ST_RUN) && (count_q != CNT_FULL);

`ifdef FIFO_RR_ARB_STRICT0_EN
    // Strict priority for requester 0, round-robin search over 1..N_REQ-1 otherwise.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_ext_s    = '0;
        cand_idx_s    = '0;
        hit_s         = 1'b0;
        // rr_ptr starts at 0 after reset; 0 is not part of the ring, so begin at 1.
        rr_start_s    = (rr_ptr_q == '0) ? SRC_BITS'(1) : rr_ptr_q;
        if (req_valid[0]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = '0;
        end else begin
            for (int k = 0; k < N_REQ - 1; k++) begin
                cand_ext_s    = {1'b0, rr_start_s} + (SRC_BITS + 1)'(k);
                // Wrap N_REQ back to 1, skipping index 0.
                cand_ext_s    = (cand_ext_s >= N_REQ_EXT) ? (cand_ext_s - N_RR_EXT) : cand_ext_s;
                cand_idx_s    = cand_ext_s[SRC_BITS-1:0];
                hit_s         = !grant_found_s && req_valid[cand_idx_s];
                grant_idx_s   = hit_s ? cand_idx_s : grant_idx_s;
                grant_found_s = grant_found_s | hit_s;
            end
        end
    end
`else
    // Round-robin search: first valid requester at rr_ptr, rr_ptr+1, ... modulo N_REQ.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_ext_s    = '0;
        cand_idx_s    = '0;
        hit_s         = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_ext_s    = {1'b0, rr_ptr_q} + (SRC_BITS + 1)'(k);
            cand_ext_s    = (cand_ext_s >= N_REQ_EXT) ? (cand_ext_s - N_REQ_EXT) : cand_ext_s;
            cand_idx_s    = cand_ext_s[SRC_BITS-1:0];
            hit_s         = !grant_found_s && req_valid[cand_idx_s];
            grant_idx_s   = hit_s ? cand_idx_s : grant_idx_s;
            grant_found_s = grant_found_s | hit_s;
        end
    end
`endif

    // A found grant implies req_valid is high, so ready alone marks a transfer.
    assign push_s = can_grant_s && grant_found_s;

    // One-hot ready for the granted requester.
    always_comb begin
        req_ready = '0;
        if (push_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Head port; m_data/m_src are don't-care while empty.
    assign m_valid  = aresetn && (state_q == ST_RUN) && (count_q != '0);
    assign m_data   = mem_data_q[rd_ptr_q];
    assign m_src    = mem_src_q[rd_ptr_q];
    assign pop_s    = m_valid && m_ready;

    // Internal pop used by the flush sequencer.
    assign drain_s  = (state_q == ST_FLUSH) && (count_q != '0);
    assign rd_adv_s = pop_s || drain_s;

    // Flush completes in the FLUSH cycle that finds the queue empty.
    assign flush_done = (state_q == ST_FLUSH) && (count_q == '0);
    assign n_entries  = count_q;

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // flush input is ignored here.
                if (count_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Round-robin pointer next-state.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
`ifdef FIFO_RR_ARB_STRICT0_EN
        // Grants to requester 0 leave the ring position untouched.
        if (push_s && (grant_idx_s != '0)) begin
            rr_ptr_d = (grant_idx_s == SRC_LAST) ? SRC_BITS'(1) : (grant_idx_s + SRC_BITS'(1));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
`else
        if (push_s) begin
            rr_ptr_d = (grant_idx_s == SRC_LAST) ? '0 : (grant_idx_s + SRC_BITS'(1));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
`endif
    end

    // Queue pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : (wr_ptr_q + PTR_BITS'(1));
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_adv_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : (rd_ptr_q + PTR_BITS'(1));
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, rd_adv_s})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbiter and queue control registers; reset discards all queued entries.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage write; contents deliberately survive reset.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            mem_data_q[wr_ptr_q] <= req_word_s[grant_idx_s];
            mem_src_q[wr_ptr_q]  <= grant_idx_s;
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_arbiter
//
// Directed self-checking bench for fifo_rr_arbiter with default parameters
// (N_REQ=4, DATA_BITS=64, FIFO_SIZE=8). Inputs change 1 time unit after the
// rising edge. Outputs are checked 1 time unit later, well away from the edge.
// ---------------------------------------------------------------------------
module tb_fifo_rr_arbiter;

    localparam int N_REQ     = 4;
    localparam int DATA_BITS = 64;
    localparam int FIFO_SIZE = 8;

    logic                       aclk;
    logic                       aresetn;
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ*DATA_BITS-1:0] req_data;
    logic                       m_valid;
    logic                       m_ready;
    logic [DATA_BITS-1:0]       m_data;
    logic [1:0]                 m_src;
    logic                       flush;
    logic                       flush_done;
    logic [3:0]                 n_entries;

    int n_checks;
    int n_fails;

    fifo_rr_arbiter #(
        .N_REQ     (N_REQ),
        .DATA_BITS (DATA_BITS),
        .FIFO_SIZE (FIFO_SIZE)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_src      (m_src),
        .flush      (flush),
        .flush_done (flush_done),
        .n_entries  (n_entries)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_word(input int idx, input logic [DATA_BITS-1:0] w);
        req_data[idx*DATA_BITS +: DATA_BITS] = w;
    endtask

    task automatic do_reset();
        aresetn   = 1'b0;
        req_valid = '0;
        m_ready   = 1'b0;
        flush     = 1'b0;
        tick();
        tick();
        aresetn   = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        aresetn   = 1'b0;
        req_valid = 4'b1111;
        m_ready   = 1'b1;
        flush     = 1'b0;
        #1;
        if (req_ready !== 4'b0000) begin n_fails++; $display("FAIL reset_ready_low: got %b expected 0000", req_ready); end
        n_checks++;
        if (m_valid !== 1'b0) begin n_fails++; $display("FAIL reset_mvalid_low: got %b expected 0", m_valid); end
        n_checks++;
        tick();
        tick();
        if (n_entries !== 4'd0) begin n_fails++; $display("FAIL reset_n_entries: got %0d expected 0", n_entries); end
        n_checks++;
        if (flush_done !== 1'b0) begin n_fails++; $display("FAIL reset_flush_done: got %b expected 0", flush_done); end
        n_checks++;
        req_valid = '0;
        m_ready   = 1'b0;
        aresetn   = 1'b1;
        #1;
        if (m_valid !== 1'b0) begin n_fails++; $display("FAIL reset_empty_mvalid: got %b expected 0", m_valid); end
        n_checks++;
    endtask

`ifndef FIFO_RR_ARB_STRICT0_EN
    task automatic test_rr_order();
        logic [N_REQ-1:0] exp_ready;
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_word(i, 64'hA0 + 64'(i));
        req_valid = 4'b1111;
        m_ready   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_ready = 4'b0001 << (i % 4);
            if (req_ready !== exp_ready) begin n_fails++; $display("FAIL rr_ready cyc %0d: got %b expected %b", i, req_ready, exp_ready); end
            n_checks++;
            if (n_entries !== ((i == 0) ? 4'd0 : 4'd1)) begin n_fails++; $display("FAIL rr_n_entries cyc %0d: got %0d", i, n_entries); end
            n_checks++;
            if (i > 0) begin
                if (m_valid !== 1'b1 || m_src !== 2'((i - 1) % 4) || m_data !== (64'hA0 + 64'((i - 1) % 4))) begin
                    n_fails++;
                    $display("FAIL rr_head cyc %0d: got v=%b src=%0d data=%h expected v=1 src=%0d data=%h",
                             i, m_valid, m_src, m_data, (i - 1) % 4, 64'hA0 + 64'((i - 1) % 4));
                end
                n_checks++;
            end
            tick();
        end
        req_valid = '0;
        tick();
        if (n_entries !== 4'd0) begin n_fails++; $display("FAIL rr_drained: got %0d expected 0", n_entries); end
        n_checks++;
    endtask
`else
    task automatic test_strict0();
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_word(i, 64'hB0 + 64'(i));
        m_ready   = 1'b1;
        req_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (req_ready !== 4'b0001) begin n_fails++; $display("FAIL strict_zero_wins cyc %0d: got %b expected 0001", i, req_ready); end
            n_checks++;
            tick();
        end
        req_valid = 4'b1000;
        #1;
        if (req_ready !== 4'b1000) begin n_fails++; $display("FAIL strict_three_alone: got %b expected 1000", req_ready); end
        n_checks++;
        // Move rr_ptr to 3 via a grant to 2, then check grants to 0 leave it there.
        do_reset();
        m_ready   = 1'b1;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b1111;
        tick();
        tick();
        req_valid = 4'b1110;
        #1;
        if (req_ready !== 4'b1000) begin n_fails++; $display("FAIL strict_rr_kept: got %b expected 1000", req_ready); end
        n_checks++;
        tick();
        #1;
        if (req_ready !== 4'b0010) begin n_fails++; $display("FAIL strict_rr_wrap_skip0: got %b expected 0010", req_ready); end
        n_checks++;
        req_valid = '0;
        tick();
    endtask
`endif

    task automatic test_fill_full();
        do_reset();
        req_valid = 4'b0100;
        m_ready   = 1'b0;
        for (int k = 0; k < FIFO_SIZE; k++) begin
            set_word(2, 64'h20 + 64'(k));
            #1;
            if (req_ready !== 4'b0100 || n_entries !== 4'(k)) begin
                n_fails++;
                $display("FAIL fill_accept k=%0d: got ready=%b n=%0d expected ready=0100 n=%0d", k, req_ready, n_entries, k);
            end
            n_checks++;
            tick();
        end
        #1;
        if (n_entries !== 4'd8 || req_ready !== 4'b0000) begin
            n_fails++; $display("FAIL fill_full: got n=%0d ready=%b expected n=8 ready=0000", n_entries, req_ready);
        end
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 64'h20 || m_src !== 2'd2) begin
            n_fails++; $display("FAIL fill_head: got v=%b data=%h src=%0d expected v=1 data=20 src=2", m_valid, m_data, m_src);
        end
        n_checks++;
        m_ready = 1'b1;
        #1;
        if (req_ready !== 4'b0000) begin n_fails++; $display("FAIL full_no_passthrough: got %b expected 0000", req_ready); end
        n_checks++;
        tick();
        m_ready = 1'b0;
        set_word(2, 64'h28);
        #1;
        if (n_entries !== 4'd7 || req_ready !== 4'b0100 || m_data !== 64'h21) begin
            n_fails++; $display("FAIL full_after_pop: got n=%0d ready=%b data=%h expected n=7 ready=0100 data=21", n_entries, req_ready, m_data);
        end
        n_checks++;
        tick();
        req_valid = '0;
        #1;
        if (n_entries !== 4'd8) begin n_fails++; $display("FAIL full_refill: got %0d expected 8", n_entries); end
        n_checks++;
        m_ready = 1'b1;
        for (int j = 0; j < FIFO_SIZE; j++) begin
            #1;
            if (m_valid !== 1'b1 || m_data !== (64'h21 + 64'(j)) || m_src !== 2'd2) begin
                n_fails++; $display("FAIL full_drain j=%0d: got v=%b data=%h src=%0d expected data=%h", j, m_valid, m_data, m_src, 64'h21 + 64'(j));
            end
            n_checks++;
            tick();
        end
        if (n_entries !== 4'd0 || m_valid !== 1'b0) begin
            n_fails++; $display("FAIL full_empty: got n=%0d v=%b expected n=0 v=0", n_entries, m_valid);
        end
        n_checks++;
        m_ready = 1'b0;
    endtask

    task automatic test_push_pop();
        do_reset();
        req_valid = 4'b0010;
        m_ready   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_word(1, 64'h10 + 64'(k));
            tick();
        end
        m_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            set_word(1, 64'h13 + 64'(j));
            #1;
            if (n_entries !== 4'd3 || m_data !== (64'h10 + 64'(j)) || req_ready !== 4'b0010) begin
                n_fails++; $display("FAIL pushpop j=%0d: got n=%0d data=%h ready=%b expected n=3 data=%h ready=0010",
                                    j, n_entries, m_data, req_ready, 64'h10 + 64'(j));
            end
            n_checks++;
            tick();
        end
        req_valid = '0;
        for (int j = 0; j < 3; j++) begin
            #1;
            if (m_data !== (64'h15 + 64'(j)) || m_src !== 2'd1) begin
                n_fails++; $display("FAIL pushpop_tail j=%0d: got data=%h src=%0d expected data=%h src=1", j, m_data, m_src, 64'h15 + 64'(j));
            end
            n_checks++;
            tick();
        end
        // Pointers have wrapped; the next word lands in slot 0.
        m_ready   = 1'b0;
        req_valid = 4'b0010;
        set_word(1, 64'h18);
        tick();
        req_valid = '0;
        #1;
        if (m_valid !== 1'b1 || m_data !== 64'h18 || n_entries !== 4'd1) begin
            n_fails++; $display("FAIL pushpop_wrap: got v=%b data=%h n=%0d expected v=1 data=18 n=1", m_valid, m_data, n_entries);
        end
        n_checks++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        req_valid = 4'b1000;
        m_ready   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_word(3, 64'h30 + 64'(k));
            tick();
        end
        req_valid = '0;
        flush     = 1'b1;
        #1;
        if (m_valid !== 1'b1 || n_entries !== 4'd5) begin
            n_fails++; $display("FAIL flush_pre: got v=%b n=%0d expected v=1 n=5", m_valid, n_entries);
        end
        n_checks++;
        tick();
        flush     = 1'b0;
        req_valid = 4'b1000;
        m_ready   = 1'b1;
        set_word(3, 64'h3F);
        for (int j = 0; j < 5; j++) begin
            #1;
            if (m_valid !== 1'b0 || req_ready !== 4'b0000 || flush_done !== 1'b0 || n_entries !== 4'(5 - j)) begin
                n_fails++; $display("FAIL flush_drain j=%0d: got v=%b ready=%b done=%b n=%0d expected v=0 ready=0000 done=0 n=%0d",
                                    j, m_valid, req_ready, flush_done, n_entries, 5 - j);
            end
            n_checks++;
            tick();
        end
        #1;
        if (flush_done !== 1'b1 || n_entries !== 4'd0 || m_valid !== 1'b0 || req_ready !== 4'b0000) begin
            n_fails++; $display("FAIL flush_done_pulse: got done=%b n=%0d v=%b ready=%b expected done=1 n=0 v=0 ready=0000",
                                flush_done, n_entries, m_valid, req_ready);
        end
        n_checks++;
        tick();
        #1;
        if (flush_done !== 1'b0 || req_ready !== 4'b1000 || m_valid !== 1'b0) begin
            n_fails++; $display("FAIL flush_resume: got done=%b ready=%b v=%b expected done=0 ready=1000 v=0", flush_done, req_ready, m_valid);
        end
        n_checks++;
        tick();
        req_valid = '0;
        #1;
        if (m_valid !== 1'b1 || m_data !== 64'h3F || m_src !== 2'd3 || n_entries !== 4'd1) begin
            n_fails++; $display("FAIL flush_next_push: got v=%b data=%h src=%0d n=%0d expected v=1 data=3f src=3 n=1",
                                m_valid, m_data, m_src, n_entries);
        end
        n_checks++;
        tick();
        // Flushing an empty queue: enter FLUSH, then pulse and return.
        m_ready = 1'b0;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        #1;
        if (flush_done !== 1'b1 || m_valid !== 1'b0 || n_entries !== 4'd0) begin
            n_fails++; $display("FAIL flush_empty_pulse: got done=%b v=%b n=%0d expected done=1 v=0 n=0", flush_done, m_valid, n_entries);
        end
        n_checks++;
        tick();
        if (flush_done !== 1'b0) begin n_fails++; $display("FAIL flush_empty_end: got %b expected 0", flush_done); end
        n_checks++;
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        req_valid = 4'b0001;
        m_ready   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_word(0, 64'h50 + 64'(k));
            tick();
        end
        req_valid = '0;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        #1;
        if (n_entries !== 4'd3 || m_valid !== 1'b0) begin
            n_fails++; $display("FAIL midflush_in_flush: got n=%0d v=%b expected n=3 v=0", n_entries, m_valid);
        end
        n_checks++;
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            if (n_entries !== 4'd0 || flush_done !== 1'b0 || m_valid !== 1'b0) begin
                n_fails++; $display("FAIL midflush_after j=%0d: got n=%0d done=%b v=%b expected n=0 done=0 v=0", j, n_entries, flush_done, m_valid);
            end
            n_checks++;
            tick();
        end
        // rr_ptr was 1 before reset; back at 0 requester 0 wins first.
        req_valid = 4'b1111;
        #1;
        if (req_ready !== 4'b0001) begin n_fails++; $display("FAIL midflush_rr_ptr: got %b expected 0001", req_ready); end
        n_checks++;
        req_valid = '0;
        tick();
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        aresetn   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        m_ready   = 1'b0;
        flush     = 1'b0;
        test_reset();
`ifndef FIFO_RR_ARB_STRICT0_EN
        test_rr_order();
`else
        test_strict0();
`endif
        test_fill_full();
        test_push_pop();
        test_flush();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Shares one FIFO write side among N_REQ requesters using round-robin arbitration, one grant per cycle.
- Stores each accepted word together with its source index.
- Presents the queue head on a first-word-fall-through valid/ready master port.
- Sits between the RoCE per-QP command producers and the single downstream command consumer. Includes a flush sequencer that drains the queue on demand.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- DATA_BITS, 64, payload width.
- FIFO_SIZE, 8, queue depth in entries (≥2; need not be a power of two).
- SRC_BITS, $clog2(N_REQ), width of the source-index tag (derived; do not override).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- req_valid  in  N_REQ  per-requester word valid.
- req_ready  out  N_REQ  per-requester accept, one-hot or zero.
- req_data  in  N_REQ*DATA_BITS  requester i uses bits [i*DATA_BITS +: DATA_BITS].
- m_valid  out  1  queue head valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_BITS  head payload.
- m_src  out  SRC_BITS  head source index.
- flush  in  1  flush request, sampled when level-high in RUN.
- flush_done  out  1  one-cycle pulse when a flush completes.
- n_entries  out  $clog2(FIFO_SIZE+1)  current occupancy.

Behaviour:
- Reset (aresetn=0 at a clock edge): state=RUN, rr_ptr=0, wr/rd pointers=0, n_entries=0, flush_done=0.
- While aresetn is low, req_ready=0 and m_valid=0 combinationally.
- Stored payload is not cleared by reset.
- Reset mid-operation discards all queued entries and any in-progress flush.
- Arbitration (combinational):
  - Valid in RUN and not full.
  - Grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … with modulo N_REQ wrap.
  - req_ready[i]=1 only for the granted i.
  - Transfer occurs when req_valid[i] and req_ready[i] are both high.
- Pointer update: on transfer from i, rr_ptr <= (i+1) mod N_REQ. With no transfer, rr_ptr holds.
- Full: no grant while n_entries==FIFO_SIZE. This holds even if m_ready pops in the same cycle; there is no pass-through.
- Write: entry {src=i, data=req_data[i]} goes to wr_ptr. wr_ptr wraps FIFO_SIZE-1 -> 0.
- Read:
  - m_valid = (n_entries!=0) in RUN; 0 in FLUSH.
  - m_data and m_src come from rd_ptr with zero latency.
  - Pop on m_valid && m_ready; rd_ptr wraps FIFO_SIZE-1 -> 0.
- Occupancy:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
  - Never exceeds FIFO_SIZE and never underflows.
- Empty: pop is impossible; m_data content is don't-care.
- FSM RUN:
  - flush=1 -> FLUSH next cycle.
  - A push or pop in the same cycle that flush is sampled still completes.
- FSM FLUSH:
  - req_ready=0 and m_valid=0.
  - One internal pop per cycle while n_entries>0.
  - When n_entries==0: flush_done=1 for that one cycle, state -> RUN.
  - The flush input is ignored while in FLUSH.
  - Flushing an empty queue takes 2 cycles: edge 1 enters FLUSH; edge 2 sees empty, pulses flush_done and returns to RUN.
- rr_ptr is preserved across a flush.
- All outputs except flush_done and n_entries are combinational from state and inputs. flush_done and n_entries are registered or derived from registers.

Optional Feature:
- Macro: FIFO_RR_ARB_STRICT0_EN.
- When defined:
  - Requester 0 has strict priority: if req_valid[0]=1 and a grant is possible, grant 0 regardless of rr_ptr.
  - A grant to 0 does not update rr_ptr.
  - Requesters 1..N_REQ-1 round-robin among themselves; after a transfer from i, rr_ptr <= next index after i, skipping 0.
- When undefined: pure round-robin over all N_REQ requesters as described in Behaviour.

Test Plan:
- Round-robin order: all 4 req_valid high with data 0xA0..0xA3, m_ready=1, from reset -> grants 0,1,2,3,0,…; m_src sequence 0,1,2,3; m_data matches; n_entries stays ≤1.
- Fill to full: m_ready=0, requester 2 only, FIFO_SIZE=8 -> 8 accepts; n_entries=8; req_ready=0 on the 9th cycle; release m_ready for one cycle -> one pop, next cycle one accept.
- Push+pop: n_entries=3, requester 1 valid and m_ready=1 for 5 cycles -> n_entries stays 3; pointers wrap; FIFO order preserved (data 0x10..0x17 out in order).
- Flush: 5 entries queued, flush pulse -> m_valid=0 and req_ready=0 for 5 cycles; flush_done pulses on the 6th cycle; n_entries=0; the next push is accepted with m_valid=1 one cycle later.
- Reset mid-flush: aresetn low for 1 cycle during FLUSH with 3 entries -> n_entries=0, state RUN, flush_done never pulses, rr_ptr=0.
- With FIFO_RR_ARB_STRICT0_EN defined: requesters 0 and 3 continuously valid -> only 0 is granted; drop req_valid[0] -> 3 is granted; rr_ptr unchanged by grants to 0.
